// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the MIPS hazard/forwarding block:
//   - opcode and funct codes for the supported instruction subset
//   - instruction field ranges
//   - forward-mux select encodings
//   - per-stage decode record and the small compare helpers built on it
// ---------------------------------------------------------------------------
package mips_defs;

  // Instruction field ranges
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  // Opcodes
  localparam logic [5:0] SPECIAL = 6'h00;
  localparam logic [5:0] J       = 6'h02;
  localparam logic [5:0] JAL     = 6'h03;
  localparam logic [5:0] BEQ     = 6'h04;
  localparam logic [5:0] ORI     = 6'h0D;
  localparam logic [5:0] LUI     = 6'h0F;
  localparam logic [5:0] LW      = 6'h23;
  localparam logic [5:0] SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] JR      = 6'h08;
  localparam logic [5:0] MFHI    = 6'h10;
  localparam logic [5:0] MTHI    = 6'h11;
  localparam logic [5:0] MFLO    = 6'h12;
  localparam logic [5:0] MTLO    = 6'h13;
  localparam logic [5:0] MULT    = 6'h18;
  localparam logic [5:0] MULTU   = 6'h19;
  localparam logic [5:0] DIV     = 6'h1A;
  localparam logic [5:0] DIVU    = 6'h1B;
  localparam logic [5:0] ADDU    = 6'h21;
  localparam logic [5:0] SUBU    = 6'h23;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Forward selects for D-stage operands (branch/jr comparators)
  localparam logic [1:0] FWD_D_GRF    = 2'd0;
  localparam logic [1:0] FWD_D_M      = 2'd1;
  localparam logic [1:0] FWD_D_E_LINK = 2'd2;

  // Forward selects for E-stage operands (ALU/MDU inputs)
  localparam logic [1:0] FWD_E_REG    = 2'd0;
  localparam logic [1:0] FWD_E_M      = 2'd1;
  localparam logic [1:0] FWD_E_W      = 2'd2;

  // Pipeline stage a decoder instance sits in; selects its Tnew table
  typedef enum logic [1:0] {
    STAGE_D,
    STAGE_E,
    STAGE_M,
    STAGE_W
  } stage_e;

  typedef struct packed {
    logic       cal_r;
    logic       cal_i;
    logic       load;
    logic       store;
    logic       branch;
    logic       jr;
    logic       link;
    logic       md;
    logic       md_div;    // div/divu: selects the long MDU latency
    logic       mf;
    logic       mt;
    logic       regwrite;
    logic [4:0] waddr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tnew;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
  } dec_t;

  // Producer p writes register src (writes to $0 never count)
  function automatic logic writes_reg(logic [4:0] src, dec_t p);
    return p.regwrite && (p.waddr != 5'd0) && (p.waddr == src);
  endfunction

  // Consumer needs src before producer p can deliver it
  function automatic logic raw_stall(logic used, logic [4:0] src,
                                     logic [1:0] tuse, dec_t p);
    return used && writes_reg(src, p) && (tuse < p.tnew);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// ---------------------------------------------------------------------------
// hazard_decode
//   Classifies one pipeline-stage instruction for hazard resolution.
//   Ports:
//     instr  in  32   instruction word latched in this stage (0 = bubble)
//     dec    out      class flags, regwrite, write address, source fields,
//                     Tuse of rs/rt and Tnew for the stage given by STAGE
// ---------------------------------------------------------------------------
module hazard_decode
  import mips_defs::*;
#(
  parameter stage_e STAGE = STAGE_D
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       special;
  logic       unused_shamt;

  assign op           = instr[OP_HI:OP_LO];
  assign fn           = instr[FN_HI:FN_LO];
  assign special      = (op == SPECIAL);
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    // NOTE: default the whole record first so every path assigns every
    // field; a missed branch here would otherwise infer a latch.
    dec = '0;

    dec.cal_r  = special && (fn == ADDU || fn == SUBU);
    dec.cal_i  = (op == ORI) || (op == LUI);
    dec.load   = (op == LW);
    dec.store  = (op == SW);
    dec.branch = (op == BEQ);
    dec.jr     = special && (fn == JR);
    dec.link   = (op == JAL);
    dec.md     = special && (fn == MULT || fn == MULTU || fn == DIV || fn == DIVU);
    dec.md_div = special && (fn == DIV || fn == DIVU);
    dec.mf     = special && (fn == MFHI || fn == MFLO);
    dec.mt     = special && (fn == MTHI || fn == MTLO);

    dec.rs = instr[RS_HI:RS_LO];
    dec.rt = instr[RT_HI:RT_LO];

    if (dec.cal_r || dec.mf)        dec.waddr = instr[RD_HI:RD_LO];
    else if (dec.cal_i || dec.load) dec.waddr = instr[RT_HI:RT_LO];
    else if (dec.link)              dec.waddr = LINK_REG;

    dec.regwrite = dec.cal_r || dec.cal_i || dec.load || dec.mf || dec.link;

    // Tuse: branch/jr compare in D, stores need rt only in M
    dec.use_rs  = dec.branch || dec.jr || dec.cal_r || dec.cal_i ||
                  dec.load || dec.store || dec.md || dec.mt;
    dec.tuse_rs = (dec.branch || dec.jr) ? 2'd0 : 2'd1;
    dec.use_rt  = dec.branch || dec.cal_r || dec.md || dec.store;
    dec.tuse_rt = dec.branch ? 2'd0 : (dec.store ? 2'd2 : 2'd1);

    // Tnew relative to the stage this decoder observes
    case (STAGE)
      STAGE_E: begin
        if (dec.load)                              dec.tnew = 2'd2;
        else if (dec.cal_r || dec.cal_i || dec.mf) dec.tnew = 2'd1;
        else                                       dec.tnew = 2'd0;
      end
      STAGE_M: dec.tnew = dec.load ? 2'd1 : 2'd0;
      default: dec.tnew = 2'd0;
    endcase
  end

endmodule

// File: rtl/hazard_unit_mdu.sv
// ---------------------------------------------------------------------------
// hazard_unit_mdu
//   Hazard/forwarding controller for a 5-stage MIPS pipeline with a
//   multi-cycle multiply/divide unit and a saturating stall counter.
//   CNT_W must satisfy 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES).
//   Ports:
//     clk           in   1       rising-edge clock
//     reset         in   1       synchronous, active-high
//     instr_d/e/m/w in   32      instruction words of the D/E/M/W stages
//     stall         out  1       freeze PC and F/D, bubble into D/E
//     md_start      out  1       MDU latches E-stage operands this cycle
//     md_busy       out  1       MDU result pending
//     fwd_rs_d      out  2       D rs select: 0 GRF, 1 M result, 2 E link (PC+8)
//     fwd_rt_d      out  2       D rt select, same encoding
//     fwd_rs_e      out  2       E rs select: 0 reg, 1 M result, 2 W write data
//     fwd_rt_e      out  2       E rt select, same encoding
//     fwd_rt_m      out  1       M store data from W write data
//     stall_cycles  out  PERF_W  cycles with stall=1, saturating
// ---------------------------------------------------------------------------
module hazard_unit_mdu
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic [31:0]       instr_e,
  input  logic [31:0]       instr_m,
  input  logic [31:0]       instr_w,
  output logic              stall,
  output logic              md_start,
  output logic              md_busy,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  dec_t dec_d, dec_e, dec_m, dec_w;

  hazard_decode #(.STAGE(STAGE_D)) u_dec_d (.instr(instr_d), .dec(dec_d));
  hazard_decode #(.STAGE(STAGE_E)) u_dec_e (.instr(instr_e), .dec(dec_e));
  hazard_decode #(.STAGE(STAGE_M)) u_dec_m (.instr(instr_m), .dec(dec_m));
  hazard_decode #(.STAGE(STAGE_W)) u_dec_w (.instr(instr_w), .dec(dec_w));

  // Not every decoded field is consumed at every stage
  logic unused_dec;
  assign unused_dec = ^{dec_d, dec_e, dec_m, dec_w};

  logic [CNT_W-1:0] md_cnt;
  logic             stall_raw;
  logic             stall_md;
  logic             md_start_raw;
  logic             m_has_result;

  // ---------------- stall ----------------
  assign stall_raw = raw_stall(dec_d.use_rs, dec_d.rs, dec_d.tuse_rs, dec_e) ||
                     raw_stall(dec_d.use_rs, dec_d.rs, dec_d.tuse_rs, dec_m) ||
                     raw_stall(dec_d.use_rt, dec_d.rt, dec_d.tuse_rt, dec_e) ||
                     raw_stall(dec_d.use_rt, dec_d.rt, dec_d.tuse_rt, dec_m);

  // E never stalls, so an md in E is exactly one cycle long: that is the start pulse.
  // HI/LO users in D wait out both the start cycle and the busy window.
  assign md_start_raw = dec_e.md;
  assign stall_md     = (dec_d.md || dec_d.mf || dec_d.mt) && (md_busy || md_start_raw);

  assign stall    = !reset && (stall_raw || stall_md);
  assign md_start = !reset && md_start_raw;

  // ---------------- forwarding ----------------
  // An M-stage value is only available on the bypass bus once the ALU, link
  // or HI/LO read has produced it; loads arrive later through W.
  assign m_has_result = dec_m.cal_r || dec_m.cal_i || dec_m.link || dec_m.mf;

  always_comb begin
    fwd_rs_d = FWD_D_GRF;
    fwd_rt_d = FWD_D_GRF;
    fwd_rs_e = FWD_E_REG;
    fwd_rt_e = FWD_E_REG;
    fwd_rt_m = 1'b0;

    if (!reset) begin
      // Newest producer first: E link, then M, then W
      if (dec_e.link && writes_reg(dec_d.rs, dec_e))       fwd_rs_d = FWD_D_E_LINK;
      else if (m_has_result && writes_reg(dec_d.rs, dec_m)) fwd_rs_d = FWD_D_M;

      if (dec_e.link && writes_reg(dec_d.rt, dec_e))       fwd_rt_d = FWD_D_E_LINK;
      else if (m_has_result && writes_reg(dec_d.rt, dec_m)) fwd_rt_d = FWD_D_M;

      if (m_has_result && writes_reg(dec_e.rs, dec_m)) fwd_rs_e = FWD_E_M;
      else if (writes_reg(dec_e.rs, dec_w))            fwd_rs_e = FWD_E_W;

      if (m_has_result && writes_reg(dec_e.rt, dec_m)) fwd_rt_e = FWD_E_M;
      else if (writes_reg(dec_e.rt, dec_w))            fwd_rt_e = FWD_E_W;

      fwd_rt_m = writes_reg(dec_m.rt, dec_w);
    end
  end

  // ---------------- MDU busy counter ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_raw) begin
      md_cnt <= dec_e.md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

  // ---------------- stall performance counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
